// File: rtl/seq_mult_pw_pkg.sv
// Shared types and helpers for the seq_mult_pw sequential multiplier.
// The optional early-termination mode is selected by SEQ_MULT_PW_EARLY_TERM_EN.
package seq_mult_pw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_cw(input int w);
    return $clog2(w + 1);
  endfunction

  // True when a two's-complement operand must be replaced by its magnitude.
  function automatic logic take_neg(input logic is_signed, input logic msb);
    return is_signed & msb;
  endfunction

  // Bit i of -x differs from bit i of x exactly when some lower bit of x is set.
  function automatic logic tc_neg_bit(input logic x_bit, input logic lower_set,
                                      input logic neg);
    return x_bit ^ (neg & lower_set);
  endfunction

endpackage

// File: rtl/seq_mult_pw_sign.sv
// Conditional two's-complement negate: y = neg ? -x : x (N bits, wraps).
// Used for operand magnitudes at capture and for the final product sign.
module seq_mult_pw_sign
  import seq_mult_pw_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] x,
  input  logic         neg,
  output logic [N-1:0] y
);

  logic [N-1:0] lower_set;

  always_comb begin
    lower_set = '0;
    for (int i = 1; i < N; i++) begin
      lower_set[i] = lower_set[i-1] | x[i-1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit
      assign y[gi] = tc_neg_bit(x[gi], lower_set[gi], neg);
    end
  endgenerate

endmodule

// File: rtl/seq_mult_pw.sv
// Sequential shift-add W x W -> 2W multiplier with signed/unsigned mode and
// valid/ready handshakes. Define SEQ_MULT_PW_EARLY_TERM_EN to stop RUN once the multiplier empties.
module seq_mult_pw
  import seq_mult_pw_pkg::*;
#(
  parameter int W = 8,
  localparam int CW = calc_cw(W)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           is_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] p,
  output logic           busy
);

  localparam int PW = 2 * W;
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  state_t          state_q, state_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   p_q, p_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic            out_valid_q, out_valid_d;

  logic            a_neg, b_neg;
  logic [W-1:0]    a_mag, b_mag;
  logic [PW-1:0]   acc_sum, prod_signed;
  logic [W-1:0]    mplier_shr;
  logic            last_iter;
  logic            accept, release_out;

  assign a_neg = take_neg(is_signed, a[W-1]);
  assign b_neg = take_neg(is_signed, b[W-1]);

  seq_mult_pw_sign #(.N(W)) u_abs_a (
    .x   (a),
    .neg (a_neg),
    .y   (a_mag)
  );

  seq_mult_pw_sign #(.N(W)) u_abs_b (
    .x   (b),
    .neg (b_neg),
    .y   (b_mag)
  );

  assign acc_sum    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mplier_shr = mplier_q >> 1;

  // The product sign is applied to the accumulator value of the final RUN cycle.
  seq_mult_pw_sign #(.N(PW)) u_neg_p (
    .x   (acc_sum),
    .neg (neg_q),
    .y   (prod_signed)
  );

`ifdef SEQ_MULT_PW_EARLY_TERM_EN
  assign last_iter = (mplier_shr == '0) || (cnt_q == LAST_CNT);
`else
  assign last_iter = (cnt_q == LAST_CNT);
`endif

  assign accept      = (state_q == IDLE) && in_valid;
  assign release_out = (state_q == DONE) && out_valid_q && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      acc_q       <= '0;
      p_q         <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      p_q         <= p_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      neg_q       <= neg_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_iter) state_d = DONE;
      DONE:    if (release_out) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    p_d         = p_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    neg_d       = neg_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          mcand_d  = PW'(a_mag);
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = '0;
          neg_d    = is_signed & (a[W-1] ^ b[W-1]);
        end
      end
      RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_shr;
        cnt_d    = cnt_q + CW'(1);
        if (last_iter) begin
          p_d         = prod_signed;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (release_out) out_valid_d = 1'b0;
      end
      default: out_valid_d = 1'b0;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    out_valid = out_valid_q;
    p         = p_q;
  end

endmodule
